// File: rtl/matmat_arbiter.sv
// rtl/matmat_arbiter.sv - round-robin front end sharing one matmat engine between two requesters
module matmat_arbiter #(
    parameter int  DATA_WIDTH  = 32,
    parameter int  BIN_POS     = 16,
    parameter int  MATRIX_SIZE = 2,
    parameter int  TIMEOUT     = 1024,
    localparam int MW          = MATRIX_SIZE * MATRIX_SIZE * DATA_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [2*MW-1:0] req_a,
    input  logic [2*MW-1:0] req_b,
    output logic [1:0]      rsp_valid,
    input  logic [1:0]      rsp_ready,
    output logic [MW-1:0]   rsp_data,
    output logic            rsp_err,
    output logic            eng_rst,
    output logic [MW-1:0]   eng_a,
    output logic [MW-1:0]   eng_b,
    input  logic            eng_complete,
    input  logic [MW-1:0]   eng_mul,
    output logic            busy,
    output logic            grant_id
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // The watchdog only ever holds 0..TIMEOUT-1; the last RUN cycle is detected by compare.
    localparam int             WW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [WW-1:0]  WDOG_LAST = WW'(TIMEOUT - 1);

    if (TIMEOUT < 1 || BIN_POS < 0 || BIN_POS >= DATA_WIDTH) begin : g_bad_params
        $error("matmat_arbiter: TIMEOUT must be >= 1 and BIN_POS within DATA_WIDTH");
    end

    logic [1:0]    state_q, state_d;
    logic [MW-1:0] eng_a_q, eng_a_d;
    logic [MW-1:0] eng_b_q, eng_b_d;
    logic [MW-1:0] rsp_data_q, rsp_data_d;
    logic          rsp_err_q, rsp_err_d;
    logic          grant_q, grant_d;
    logic [1:0]    start_cnt_q, start_cnt_d;
    logic [WW-1:0] wdog_q, wdog_d;
    logic          grant_sel;

    always_comb begin
        state_d     = state_q;
        eng_a_d     = eng_a_q;
        eng_b_d     = eng_b_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        grant_d     = grant_q;
        start_cnt_d = start_cnt_q;
        wdog_d      = wdog_q;
        req_ready   = 2'b00;
        rsp_valid   = 2'b00;
        eng_rst     = 1'b1;
        // On a tie the requester that did not own the last job wins.
        grant_sel   = (req_valid == 2'b11) ? ~grant_q : req_valid[1];

        case (state_q)
            S_IDLE: begin
                req_ready = {grant_sel & req_valid[1], ~grant_sel & req_valid[0]};
                if (|req_valid) begin
                    eng_a_d     = grant_sel ? req_a[2*MW-1:MW] : req_a[MW-1:0];
                    eng_b_d     = grant_sel ? req_b[2*MW-1:MW] : req_b[MW-1:0];
                    grant_d     = grant_sel;
                    start_cnt_d = 2'd0;
                    state_d     = S_START;
                end
            end
            S_START: begin
                if (start_cnt_q == 2'd1) begin
                    wdog_d  = '0;
                    state_d = S_RUN;
                end else begin
                    start_cnt_d = start_cnt_q + 2'd1;
                end
            end
            S_RUN: begin
                eng_rst = 1'b0;
                if (eng_complete) begin
                    rsp_data_d = eng_mul;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (wdog_q == WDOG_LAST) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end else begin
                    wdog_d = wdog_q + WW'(1);
                end
            end
            S_RESP: begin
                rsp_valid = {grant_q, ~grant_q};
                if (rsp_ready[grant_q]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            eng_a_q     <= '0;
            eng_b_q     <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            grant_q     <= 1'b1;
            start_cnt_q <= 2'd0;
            wdog_q      <= '0;
        end else begin
            state_q     <= state_d;
            eng_a_q     <= eng_a_d;
            eng_b_q     <= eng_b_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            grant_q     <= grant_d;
            start_cnt_q <= start_cnt_d;
            wdog_q      <= wdog_d;
        end
    end

    assign eng_a    = eng_a_q;
    assign eng_b    = eng_b_q;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;
    assign busy     = (state_q != S_IDLE);
    assign grant_id = grant_q;

endmodule
